// File: rtl/sll_shifter_pkg.sv
// Shared definitions for the execute-stage shifters and ALU decode:
// function codes, datapath widths and the sequential SLL state encoding.
package sll_shifter_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned AMT_W   = 5;
    localparam int unsigned STAGE_W = 3;
    localparam int unsigned FUNC_W  = 6;

    // Function codes shared with the SRL shifter and the ALU decoder.
    localparam logic [FUNC_W-1:0] FUNC_SLL = 6'b000000;
    localparam logic [FUNC_W-1:0] FUNC_SRL = 6'b000010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sll_stage.sv
// One binary stage of the left shifter: shifts by 2^stage when enabled,
// passes the operand through otherwise. Purely combinational.
//   i_data   : operand
//   i_stage  : stage index 0..4 (shift distance 1,2,4,8,16)
//   i_en     : apply this stage's shift
//   o_data_c : shifted (or passed-through) operand, zero filled from the LSB
module sll_stage
    import sll_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0]   i_data,
    input  logic [STAGE_W-1:0] i_stage,
    input  logic               i_en,
    output logic [WIDTH-1:0]   o_data_c
);

    logic [5:0] w_dist;

    // Distance 2^stage; stages above 4 never occur while shifting.
    assign w_dist   = 6'(1) << i_stage;
    assign o_data_c = i_en ? (i_data << w_dist) : i_data;

endmodule

// File: rtl/sll_shifter.sv
// Sequential shift-left-logical unit with a fixed 5-cycle shift phase.
// The 5-bit amount is resolved one binary stage per cycle (1,2,4,8,16),
// so latency depends only on the function code. Non-SLL codes produce 0
// so the ALU can OR this result with the other shifter outputs.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, sampled only when idle
//   dataA    : operand to shift
//   dataB    : shift amount, only [4:0] used
//   Signal   : function code
//   busy     : high while shifting and during the done cycle
//   done     : one-cycle pulse, dataOut valid
//   dataOut  : result register, held until the next done
module sll_shifter
    import sll_shifter_pkg::*;
#(
    parameter int unsigned         WIDTH = DATA_W,
    parameter logic [FUNC_W-1:0]   SLL   = FUNC_SLL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    input  logic [FUNC_W-1:0]  Signal,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   dataOut
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic [AMT_W-1:0]     r_amt;
    logic [AMT_W-1:0]     w_amt_nxt;
    logic [STAGE_W-1:0]   r_stage;
    logic [STAGE_W-1:0]   w_stage_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic [WIDTH-1:0]     r_dout;
    logic [WIDTH-1:0]     w_dout_nxt;
    logic [WIDTH-1:0]     w_shifted;
    logic                 w_en;
    logic                 w_unused_amt_hi;

    // Upper amount bits are architecturally ignored.
    assign w_unused_amt_hi = ^dataB[WIDTH-1:AMT_W];

    // Amount bit selecting whether the current stage shifts.
    assign w_en = r_amt[r_stage];

    sll_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .i_data   (r_acc),
        .i_stage  (r_stage),
        .i_en     (w_en),
        .o_data_c (w_shifted)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_amt   <= '0;
            r_stage <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_amt   <= w_amt_nxt;
            r_stage <= w_stage_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_dout  <= w_dout_nxt;
        end
    end

    // Next-state and next-register values; busy/done are decoded one cycle
    // ahead so they come straight from flops.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_amt_nxt   = r_amt;
        w_stage_nxt = r_stage;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_dout_nxt  = r_dout;

        unique case (r_state)
            IDLE: begin
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_busy_nxt = 1'b1;
                    if (Signal == SLL) begin
                        w_acc_nxt   = dataA;
                        w_amt_nxt   = dataB[AMT_W-1:0];
                        w_stage_nxt = '0;
                        w_state_nxt = SHIFT;
                    end else begin
                        w_acc_nxt   = '0;
                        w_dout_nxt  = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            SHIFT: begin
                w_acc_nxt   = w_shifted;
                w_stage_nxt = r_stage + 3'd1;
                // Always runs all five stages, even for a zero amount.
                if (r_stage == 3'd4) begin
                    w_dout_nxt  = w_shifted;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign dataOut = r_dout;

endmodule
